// File: rtl/ir_prefix_seq_pkg.sv
// Shared core decode definitions: prefix bit layout, common prefix
// constants and the prefix sequencer state type (also used by pla_decode).
package ir_prefix_seq_pkg;

  // Prefix vector layout {IXY0, IXY1, XX, CB, ED}
  localparam int unsigned PFX_ED   = 0;
  localparam int unsigned PFX_CB   = 1;
  localparam int unsigned PFX_XX   = 2;
  localparam int unsigned PFX_IXY1 = 3;
  localparam int unsigned PFX_IXY0 = 4;

  localparam logic [4:0] PFX_XX_IXY0 = 5'b10100;
  localparam logic [4:0] PFX_XX_IXY1 = 5'b01100;

  // Opcode-group selectors, one-hot over {XX, CB, ED}
  localparam logic [2:0] GRP_XX = 3'b100;
  localparam logic [2:0] GRP_CB = 3'b010;
  localparam logic [2:0] GRP_ED = 3'b001;

  typedef enum logic [2:0] {
    ST_OPC,
    ST_XY,
    ST_CB,
    ST_ED,
    ST_XYCB_D,
    ST_XYCB_OP,
    ST_EXEC
  } seq_state_t;

  // Build a prefix vector from the index flag and an opcode group
  function automatic logic [4:0] make_prefix(input logic ixy, input logic [2:0] grp);
    logic [4:0] p;
    p           = '0;
    p[PFX_IXY0] = ~ixy;
    p[PFX_IXY1] = ixy;
    p[PFX_XX]   = grp[2];
    p[PFX_CB]   = grp[1];
    p[PFX_ED]   = grp[0];
    return p;
  endfunction

endpackage

// File: rtl/ir_prefix_seq.sv
// Instruction prefix sequencer: collects DD/FD/CB/ED prefix bytes and the
// optional displacement, then presents a complete prefix/opcode to decode.
module ir_prefix_seq
  import ir_prefix_seq_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] db,
  input  logic       byte_we,
  input  logic       insn_done,
  input  logic       inject_nop,
  output logic [4:0] prefix,
  output logic [7:0] opcode,
  output logic       use_iy,
  output logic [7:0] disp,
  output logic       opcode_valid,
  output logic       fetch_more
);

  seq_state_t state, state_n;
  logic [4:0] prefix_n;
  logic [7:0] opcode_n;
  logic       use_iy_n;
  logic [7:0] disp_n;
  logic       ixy, ixy_n;
  logic [7:0] fbyte;
  logic       is_index;

  // State and output registers; reset overrides every other input
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_OPC;
      prefix <= PFX_XX_IXY0;
      opcode <= '0;
      use_iy <= 1'b0;
      disp   <= '0;
      ixy    <= 1'b0;
    end else begin
      state  <= state_n;
      prefix <= prefix_n;
      opcode <= opcode_n;
      use_iy <= use_iy_n;
      disp   <= disp_n;
      ixy    <= ixy_n;
    end
  end

  // Byte classification, next-state and next-output selection
  always_comb begin
    state_n  = state;
    prefix_n = prefix;
    opcode_n = opcode;
    use_iy_n = use_iy;
    disp_n   = disp;
    ixy_n    = ixy;
    fbyte    = inject_nop ? 8'h00 : db;
    is_index = (fbyte == 8'hDD) || (fbyte == 8'hFD);

    if (insn_done) begin
      // Completion in EXEC and abort elsewhere share the same return path
      state_n  = ST_OPC;
      prefix_n = PFX_XX_IXY0;
      opcode_n = '0;
      use_iy_n = 1'b0;
      ixy_n    = 1'b0;
    end else if (byte_we && state != ST_EXEC) begin
      case (state)
        ST_OPC: begin
          if (is_index) begin
            state_n  = ST_XY;
            ixy_n    = 1'b1;
            use_iy_n = fbyte[5];
          end else if (fbyte == 8'hCB) begin
            state_n = ST_CB;
          end else if (fbyte == 8'hED) begin
            state_n = ST_ED;
          end else begin
            opcode_n = fbyte;
            prefix_n = PFX_XX_IXY0;
            state_n  = ST_EXEC;
          end
        end
        ST_XY: begin
          if (is_index) begin
            use_iy_n = fbyte[5];
          end else if (fbyte == 8'hCB) begin
            state_n = ST_XYCB_D;
          end else if (fbyte == 8'hED) begin
            state_n = ST_ED;
          end else begin
            opcode_n = fbyte;
            prefix_n = PFX_XX_IXY1;
            state_n  = ST_EXEC;
          end
        end
        ST_CB: begin
          opcode_n = fbyte;
          prefix_n = make_prefix(ixy, GRP_CB);
          state_n  = ST_EXEC;
        end
        ST_ED: begin
          opcode_n = fbyte;
          prefix_n = make_prefix(ixy, GRP_ED);
          state_n  = ST_EXEC;
        end
        ST_XYCB_D: begin
          disp_n  = fbyte;
          state_n = ST_XYCB_OP;
        end
        ST_XYCB_OP: begin
          opcode_n = fbyte;
          prefix_n = make_prefix(1'b1, GRP_CB);
          state_n  = ST_EXEC;
        end
        default: begin
          state_n  = ST_OPC;
          prefix_n = PFX_XX_IXY0;
          opcode_n = '0;
          use_iy_n = 1'b0;
          ixy_n    = 1'b0;
        end
      endcase
    end
  end

  assign opcode_valid = (state == ST_EXEC);
  assign fetch_more   = (state != ST_EXEC);

endmodule

// File: tb/tb_ir_prefix_seq.sv
// Self-checking bench for ir_prefix_seq: directed instruction sequences plus
// randomized byte streams checked against a byte-queue decoding model.
module tb_ir_prefix_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] db = '0;
  logic       byte_we = 1'b0;
  logic       insn_done = 1'b0;
  logic       inject_nop = 1'b0;
  logic [4:0] prefix;
  logic [7:0] opcode;
  logic       use_iy;
  logic [7:0] disp;
  logic       opcode_valid;
  logic       fetch_more;

  int n_checks = 0;
  int n_fails  = 0;

  ir_prefix_seq dut (
    .clk(clk), .reset(reset), .db(db), .byte_we(byte_we),
    .insn_done(insn_done), .inject_nop(inject_nop), .prefix(prefix),
    .opcode(opcode), .use_iy(use_iy), .disp(disp),
    .opcode_valid(opcode_valid), .fetch_more(fetch_more)
  );

  always #5 clk = ~clk;

  // Reference model: bytes of the instruction in flight, decoded as a whole
  logic [7:0] mq[$];
  logic       m_exec = 1'b0;
  logic [4:0] m_prefix = 5'b10100;
  logic [7:0] m_opcode = 8'h00;
  logic       m_use_iy = 1'b0;
  logic [7:0] m_disp = 8'h00;

  task automatic model_byte(input logic [7:0] b);
    int i;
    logic ixy, iy, done;
    logic [7:0] op;
    logic [4:0] pf;
    mq.push_back(b);
    i = 0; ixy = 1'b0; iy = 1'b0; done = 1'b0; op = 8'h00; pf = 5'b10100;
    while (i < mq.size() && (mq[i] == 8'hDD || mq[i] == 8'hFD)) begin
      ixy = 1'b1;
      iy  = (mq[i] == 8'hFD);
      i++;
    end
    m_use_iy = iy;
    if (i < mq.size()) begin
      if (mq[i] == 8'hCB) begin
        if (ixy) begin
          if (mq.size() >= i + 2) m_disp = mq[i+1];
          if (mq.size() == i + 3) begin done = 1'b1; op = mq[i+2]; pf = 5'b01010; end
        end else if (mq.size() == i + 2) begin
          done = 1'b1; op = mq[i+1]; pf = 5'b10010;
        end
      end else if (mq[i] == 8'hED) begin
        if (mq.size() == i + 2) begin
          done = 1'b1; op = mq[i+1]; pf = ixy ? 5'b01001 : 5'b10001;
        end
      end else begin
        done = 1'b1; op = mq[i]; pf = ixy ? 5'b01100 : 5'b10100;
      end
    end
    if (done) begin
      m_exec = 1'b1; m_opcode = op; m_prefix = pf;
      mq.delete();
    end
  endtask

  // Drive one cycle of inputs, advance the model, and sample 1 time unit after the edge
  task automatic step(input logic r, input logic we, input logic [7:0] d,
                      input logic inj, input logic done);
    reset = r; byte_we = we; db = d; inject_nop = inj; insn_done = done;
    if (r) begin
      mq.delete(); m_exec = 1'b0; m_prefix = 5'b10100; m_opcode = 8'h00;
      m_use_iy = 1'b0; m_disp = 8'h00;
    end else if (done) begin
      mq.delete(); m_exec = 1'b0; m_prefix = 5'b10100; m_opcode = 8'h00;
      m_use_iy = 1'b0;
    end else if (we && !m_exec) begin
      model_byte(inj ? 8'h00 : d);
    end
    @(posedge clk);
    #1;
    reset = 1'b0; byte_we = 1'b0; inject_nop = 1'b0; insn_done = 1'b0;
  endtask

  task automatic test_reset;
    logic [23:0] obs;
    step(1'b1, 1'b1, 8'hDD, 1'b1, 1'b1);
    obs = {opcode_valid, fetch_more, prefix, opcode, use_iy, disp};
    n_checks++;
    if (obs !== {1'b0, 1'b1, 5'b10100, 8'h00, 1'b0, 8'h00}) begin
      $display("FAIL reset_state: got %h expected %h", obs,
               {1'b0, 1'b1, 5'b10100, 8'h00, 1'b0, 8'h00});
      n_fails++;
    end
  endtask

  typedef struct {
    logic [31:0] bytes;
    int          n;
    logic [4:0]  pfx;
    logic [7:0]  op;
    logic        iy;
    logic [7:0]  dsp;
  } scen_t;

  task automatic test_sequences;
    scen_t sc[6];
    logic [31:0] bv;
    logic [23:0] obs, exp;
    sc[0] = '{32'h3E000000, 1, 5'b10100, 8'h3E, 1'b0, 8'h00};
    sc[1] = '{32'hDDFD2100, 3, 5'b01100, 8'h21, 1'b1, 8'h00};
    sc[2] = '{32'hFDCB0546, 4, 5'b01010, 8'h46, 1'b1, 8'h05};
    sc[3] = '{32'hEDB00000, 2, 5'b10001, 8'hB0, 1'b0, 8'h00};
    sc[4] = '{32'hDDED4400, 3, 5'b01001, 8'h44, 1'b0, 8'h00};
    sc[5] = '{32'hCBDD0000, 2, 5'b10010, 8'hDD, 1'b0, 8'h00};
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      bv = sc[k].bytes;
      for (int j = 0; j < sc[k].n; j++) begin
        step(1'b0, 1'b1, bv[31-8*j -: 8], 1'b0, 1'b0);
        if (j < sc[k].n - 1) begin
          n_checks++;
          if ({opcode_valid, fetch_more} !== 2'b01) begin
            $display("FAIL seq%0d_midprefix byte%0d: valid/fetch got %b expected 01",
                     k, j, {opcode_valid, fetch_more});
            n_fails++;
          end
        end
      end
      obs = {opcode_valid, fetch_more, prefix, opcode, use_iy, disp};
      exp = {1'b1, 1'b0, sc[k].pfx, sc[k].op, sc[k].iy, sc[k].dsp};
      n_checks++;
      if (obs !== exp) begin
        $display("FAIL seq%0d_complete: got %h expected %h", k, obs, exp);
        n_fails++;
      end
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      obs = {opcode_valid, fetch_more, prefix, opcode, use_iy, disp};
      exp = {1'b0, 1'b1, 5'b10100, 8'h00, 1'b0, sc[k].dsp};
      n_checks++;
      if (obs !== exp) begin
        $display("FAIL seq%0d_done: got %h expected %h", k, obs, exp);
        n_fails++;
      end
    end
  endtask

  task automatic test_reset_mid_prefix;
    logic [23:0] obs;
    step(1'b0, 1'b1, 8'hDD, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'hCB, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    obs = {opcode_valid, fetch_more, prefix, opcode, use_iy, disp};
    n_checks++;
    if (obs !== {1'b1, 1'b0, 5'b10100, 8'h00, 1'b0, 8'h00}) begin
      $display("FAIL reset_mid_prefix: got %h expected %h", obs,
               {1'b1, 1'b0, 5'b10100, 8'h00, 1'b0, 8'h00});
      n_fails++;
    end
  endtask

  task automatic test_inject_and_abort;
    logic [22:0] obs;
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'hFD, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h7E, 1'b1, 1'b0);
    obs = {opcode_valid, fetch_more, prefix, opcode, use_iy};
    n_checks++;
    if (obs !== {1'b1, 1'b0, 5'b01100, 8'h00, 1'b1}) begin
      $display("FAIL inject_in_xy: got %h expected %h", obs, {1'b1, 1'b0, 5'b01100, 8'h00, 1'b1});
      n_fails++;
    end
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 1'b1, 8'hFD, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'hCB, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h12, 1'b0, 1'b1);
    obs = {opcode_valid, fetch_more, prefix, opcode, use_iy};
    n_checks++;
    if (obs !== {1'b0, 1'b1, 5'b10100, 8'h00, 1'b0}) begin
      $display("FAIL abort_mid_prefix: got %h expected %h", obs, {1'b0, 1'b1, 5'b10100, 8'h00, 1'b0});
      n_fails++;
    end
    step(1'b0, 1'b1, 8'h3E, 1'b0, 1'b0);
    obs = {opcode_valid, fetch_more, prefix, opcode, use_iy};
    n_checks++;
    if (obs !== {1'b1, 1'b0, 5'b10100, 8'h3E, 1'b0}) begin
      $display("FAIL after_abort: got %h expected %h", obs, {1'b1, 1'b0, 5'b10100, 8'h3E, 1'b0});
      n_fails++;
    end
  endtask

  task automatic test_back_to_back;
    logic [22:0] obs;
    step(1'b0, 1'b1, 8'h55, 1'b0, 1'b0);
    obs = {opcode_valid, fetch_more, prefix, opcode, use_iy};
    n_checks++;
    if (obs !== {1'b1, 1'b0, 5'b10100, 8'h3E, 1'b0}) begin
      $display("FAIL exec_ignores_byte: got %h expected %h", obs, {1'b1, 1'b0, 5'b10100, 8'h3E, 1'b0});
      n_fails++;
    end
    step(1'b0, 1'b1, 8'h66, 1'b0, 1'b1);
    obs = {opcode_valid, fetch_more, prefix, opcode, use_iy};
    n_checks++;
    if (obs !== {1'b0, 1'b1, 5'b10100, 8'h00, 1'b0}) begin
      $display("FAIL done_beats_byte: got %h expected %h", obs, {1'b0, 1'b1, 5'b10100, 8'h00, 1'b0});
      n_fails++;
    end
    step(1'b0, 1'b1, 8'h47, 1'b0, 1'b0);
    obs = {opcode_valid, fetch_more, prefix, opcode, use_iy};
    n_checks++;
    if (obs !== {1'b1, 1'b0, 5'b10100, 8'h47, 1'b0}) begin
      $display("FAIL back_to_back_next: got %h expected %h", obs, {1'b1, 1'b0, 5'b10100, 8'h47, 1'b0});
      n_fails++;
    end
  endtask

  task automatic test_random;
    logic r, we, inj, dn;
    logic [7:0] d;
    logic [23:0] obs, exp;
    int sel;
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int c = 0; c < 3000; c++) begin
      r   = ($urandom_range(0, 99) == 0);
      dn  = m_exec ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0);
      we  = ($urandom_range(0, 3) != 0);
      inj = ($urandom_range(0, 19) == 0);
      sel = $urandom_range(0, 7);
      case (sel)
        0: d = 8'hDD;
        1: d = 8'hFD;
        2: d = 8'hCB;
        3: d = 8'hED;
        default: d = 8'($urandom);
      endcase
      step(r, we, d, inj, dn);
      obs = {opcode_valid, fetch_more, prefix, opcode, use_iy, disp};
      exp = {m_exec, ~m_exec, m_prefix, m_opcode, m_use_iy, m_disp};
      n_checks++;
      if (obs !== exp) begin
        $display("FAIL random_cycle%0d: got %h expected %h", c, obs, exp);
        n_fails++;
      end
      n_checks++;
      if (!($onehot(prefix[4:3]) && $onehot(prefix[2:0]))) begin
        $display("FAIL prefix_onehot cycle%0d: got %b expected one-hot fields", c, prefix);
        n_fails++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequences();
    test_reset_mid_prefix();
    test_inject_and_abort();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/ir_prefix_seq.md
IR_PREFIX_SEQ -- requirements
Module: ir_prefix_seq

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state changes on rising edge.
REQ-002 SHALL have: reset  in  1  synchronous active-high reset, sampled on rising clk.
REQ-003 SHALL have: db  in  8  byte fetched from the bus.
REQ-004 SHALL have: byte_we  in  1  db is a valid instruction-stream byte this cycle.
REQ-005 SHALL have: insn_done  in  1  execute has finished the current instruction.
REQ-006 SHALL have: inject_nop  in  1  HALT/interrupt acknowledge: force opcode 0x00 in place of db.
REQ-007 SHALL have: prefix  out  5  decode prefix {IXY0,IXY1,XX,CB,ED}, one-hot in [2:0], one-hot in [4:3].
REQ-008 SHALL have: opcode  out  8  opcode byte presented to pla_decode.
REQ-009 SHALL have: use_iy  out  1  index prefix was FD (1) or DD (0), valid when prefix[3]=1.
REQ-010 SHALL have: disp  out  8  captured displacement of a DD/FD CB d op sequence.
REQ-011 SHALL have: opcode_valid  out  1  prefix/opcode are a complete instruction.
REQ-012 SHALL have: fetch_more  out  1  sequencer is mid-prefix and needs another byte.

Function
REQ-013 SHALL implement states OPC, XY, CB, ED, XYCB_D, XYCB_OP, EXEC.
REQ-014 In OPC on byte_we: DD/FD -> XY (use_iy=db[5]); CB -> CB; ED -> ED; otherwise latch opcode=db, prefix=10100, -> EXEC.
REQ-015 In XY on byte_we: DD/FD -> stay XY, use_iy updated (last index prefix wins); CB -> XYCB_D; ED -> ED keeping IXY1; otherwise opcode=db, prefix=01100, -> EXEC.
REQ-016 In CB on byte_we: opcode=db, prefix={ixy,010}, -> EXEC; any byte value including DD/FD/CB/ED is an opcode.
REQ-017 In ED on byte_we: opcode=db, prefix={ixy,001}, -> EXEC; any byte value is an opcode.
REQ-018 In XYCB_D on byte_we: disp=db, -> XYCB_OP; in XYCB_OP on byte_we: opcode=db, prefix=01010, -> EXEC.
REQ-019 opcode/prefix SHALL update on the clock edge that accepts the final byte; opcode_valid=1 from the next cycle, 1-cycle latency.
REQ-020 In EXEC opcode_valid=1, fetch_more=0, byte_we ignored; insn_done -> OPC, prefix=10100, opcode=0x00, use_iy=0 next cycle.
REQ-021 fetch_more SHALL be 1 in OPC, XY, CB, ED, XYCB_D and XYCB_OP.
REQ-022 inject_nop with byte_we in any non-EXEC state SHALL substitute 0x00 for db.
REQ-023 inject_nop in XY SHALL therefore complete as opcode 0x00, prefix 01100.
REQ-024 insn_done outside EXEC SHALL abort the sequence and return to OPC with reset-value outputs.
REQ-025 byte_we and insn_done together in EXEC: insn_done wins, byte dropped.
REQ-026 disp SHALL hold its value until the next XYCB_D capture.
REQ-027 Exactly one of prefix[4:3] and exactly one of prefix[2:0] SHALL be set in every cycle.

Reset
REQ-028 reset SHALL force state OPC, prefix=10100, opcode=0x00, use_iy=0, disp=0x00, opcode_valid=0, fetch_more=1 on the next edge.
REQ-029 reset SHALL override byte_we, insn_done and inject_nop in the same cycle, including reset asserted mid-prefix.

Structure
REQ-030 Prefix bit positions, the constants PFX_XX_IXY0/IXY1, and the state enum SHALL live in the shared core package, also used by pla_decode.
REQ-031 SHALL be a single module with no sub-modules; byte classification is in-module combinational logic.

Verification
REQ-032 Bytes 3E -> opcode 3E, prefix 10100, opcode_valid 1 cycle later; insn_done -> 00/10100.
REQ-033 Bytes DD FD 21 -> opcode 21, prefix 01100, use_iy=1.
REQ-034 Bytes FD CB 05 46 -> disp 05, opcode 46, prefix 01010, use_iy=1.
REQ-035 Bytes ED B0 -> opcode B0, prefix 10001; bytes DD ED 44 -> opcode 44, prefix 01001.
REQ-036 Bytes CB DD -> opcode DD, prefix 10010, not treated as an index prefix.
REQ-037 reset after DD CB, then byte 00 -> opcode 00, prefix 10100, disp 00.
